// File: rtl/nios_nios2_gen2_0_cpu_mul_combine_pkg.sv
// ----------------------------------------------------------------------------
// nios_mul_pkg : shared widths and sequencer state for the multiply combiner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nios_mul_pkg;
  localparam int HALF_W   = 16;
  localparam int ITER_CNT = 16;
  localparam int CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CNT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } mul_state_e;
endpackage

`default_nettype wire

// File: rtl/nios_nios2_gen2_0_cpu_mul_combine_if.sv
// ----------------------------------------------------------------------------
// nios_nios2_gen2_0_cpu_mul_combine_if : M-stage products in, A-stage result out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface nios_nios2_gen2_0_cpu_mul_combine_if;
  logic        M_en;
  logic        M_mul_start;
  logic        M_mul_hi;
  logic [15:0] M_src1_hi;
  logic [15:0] M_src2_hi;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic [31:0] A_mul_result;
  logic        A_mul_valid;
  logic        A_mul_stall;

  modport master (
    output M_en, M_mul_start, M_mul_hi, M_src1_hi, M_src2_hi,
           M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  A_mul_result, A_mul_valid, A_mul_stall
  );

  modport slave (
    input  M_en, M_mul_start, M_mul_hi, M_src1_hi, M_src2_hi,
           M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output A_mul_result, A_mul_valid, A_mul_stall
  );
endinterface

`default_nettype wire

// File: rtl/nios_nios2_gen2_0_cpu_mul_combine_hi_seq.sv
// ----------------------------------------------------------------------------
// nios_mul_hi_seq : 16-step shift-add for hi1 x hi2 (present with MUL_HI_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifdef MUL_HI_EN
module nios_mul_hi_seq
  import nios_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [HALF_W-1:0] mcand_i,
  input  logic [HALF_W-1:0] mplier_i,
  input  logic [31:0]       acc_init_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       result_o
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       acc_q, acc_d, acc_step;
  logic [HALF_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d;

  assign acc_step = acc_q + (mplier_q[cnt_q] ? (32'(mcand_q) << cnt_q) : 32'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = ITER;
          cnt_d    = '0;
          acc_d    = acc_init_i;
          mcand_d  = mcand_i;
          mplier_d = mplier_i;
        end
      end
      ITER: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        // The last step's sum goes straight out; acc_q is not needed afterwards.
        if (cnt_q == CNT_LAST) begin
          done_o  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q == ITER);
  assign result_o = acc_step;

endmodule
`endif

`default_nettype wire

// File: rtl/nios_nios2_gen2_0_cpu_mul_combine.sv
// ----------------------------------------------------------------------------
// nios_nios2_gen2_0_cpu_mul_combine : partial products -> 32-bit A-stage result
// Optional upper-word (mulxuu) path enabled by defining MUL_HI_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nios_nios2_gen2_0_cpu_mul_combine
  import nios_mul_pkg::*;
#(
  parameter logic [31:0] OUT_RESET_VAL = 32'h0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  nios_nios2_gen2_0_cpu_mul_combine_if.slave   bus
);

  logic [HALF_W-1:0] mid;
  logic [31:0]       low_word;
  logic              accept, lo_accept;
  logic              seq_busy, seq_done;
  logic [31:0]       seq_result;
  logic [31:0]       result_q, result_d;
  logic              valid_q, valid_d;

  assign mid      = bus.M_mul_cell_p2[HALF_W-1:0] + bus.M_mul_cell_p3[HALF_W-1:0];
  assign low_word = bus.M_mul_cell_p1 + {mid, {HALF_W{1'b0}}};
  assign accept   = bus.M_en & bus.M_mul_start & ~seq_busy;

`ifdef MUL_HI_EN
  logic              hi_accept;
  logic [HALF_W+1:0] cross;
  logic [31:0]       acc_init;
  logic              unused_cross;

  assign hi_accept = accept & bus.M_mul_hi;
  assign lo_accept = accept & ~bus.M_mul_hi;

  // Carry out of bit 31 of the low word seeds the upper-word accumulator.
  assign cross = {2'b00, bus.M_mul_cell_p1[31:HALF_W]}
               + {2'b00, bus.M_mul_cell_p2[HALF_W-1:0]}
               + {2'b00, bus.M_mul_cell_p3[HALF_W-1:0]};
  assign acc_init = 32'(bus.M_mul_cell_p2[31:HALF_W])
                  + 32'(bus.M_mul_cell_p3[31:HALF_W])
                  + 32'(cross[HALF_W+1:HALF_W]);
  assign unused_cross = ^cross[HALF_W-1:0];

  nios_mul_hi_seq u_hi_seq (
    .clk        (clk),
    .reset      (reset),
    .start_i    (hi_accept),
    .mcand_i    (bus.M_src1_hi),
    .mplier_i   (bus.M_src2_hi),
    .acc_init_i (acc_init),
    .busy_o     (seq_busy),
    .done_o     (seq_done),
    .result_o   (seq_result)
  );

  assign bus.A_mul_stall = seq_busy | hi_accept;
`else
  logic unused_hi;

  assign unused_hi  = ^{bus.M_mul_hi, bus.M_src1_hi, bus.M_src2_hi,
                        bus.M_mul_cell_p2[31:HALF_W], bus.M_mul_cell_p3[31:HALF_W]};
  assign seq_busy   = 1'b0;
  assign seq_done   = 1'b0;
  assign seq_result = 32'h0;
  assign lo_accept  = accept;
  assign bus.A_mul_stall = 1'b0;
`endif

  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    if (seq_done) begin
      result_d = seq_result;
      valid_d  = 1'b1;
    end else if (lo_accept) begin
      result_d = low_word;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= OUT_RESET_VAL;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.A_mul_result = result_q;
  assign bus.A_mul_valid  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nios_nios2_gen2_0_cpu_mul_combine.sv
// ----------------------------------------------------------------------------
// tb_nios_nios2_gen2_0_cpu_mul_combine : randomized bench against a 64-bit product model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nios_nios2_gen2_0_cpu_mul_combine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_nios2_gen2_0_cpu_mul_combine_if bus();

  nios_nios2_gen2_0_cpu_mul_combine #(.OUT_RESET_VAL(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_result = 32'h0;

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic hi, input logic start, input logic en);
    bus.M_en          = en;
    bus.M_mul_start   = start;
    bus.M_mul_hi      = hi;
    bus.M_src1_hi     = a[31:16];
    bus.M_src2_hi     = b[31:16];
    bus.M_mul_cell_p1 = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
    bus.M_mul_cell_p2 = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
    bus.M_mul_cell_p3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.A_mul_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want %h", bus.A_mul_result, 32'h0); end
    n_checks++; if (bus.A_mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.A_mul_valid); end
    n_checks++; if (bus.A_mul_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.A_mul_stall); end
    reset = 1'b0;
    exp_result = 32'h0;
  endtask

  // Single low-word accept; hi_req is only honoured when the upper-word path exists.
  task automatic test_low(input logic [31:0] a, input logic [31:0] b, input logic hi_req);
    logic [63:0] prod;
    prod = ref_product(a, b);
    drive(a, b, hi_req, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.A_mul_stall !== 1'b0) begin n_fail++; $display("FAIL low_stall got %b want 0", bus.A_mul_stall); end
    @(posedge clk); #1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_result = prod[31:0];
    n_checks++; if (bus.A_mul_valid !== 1'b1) begin n_fail++; $display("FAIL low_valid got %b want 1", bus.A_mul_valid); end
    n_checks++; if (bus.A_mul_result !== exp_result) begin n_fail++; $display("FAIL low_result a=%h b=%h got %h want %h", a, b, bus.A_mul_result, exp_result); end
    @(posedge clk); #1;
    n_checks++; if (bus.A_mul_valid !== 1'b0) begin n_fail++; $display("FAIL low_valid_pulse got %b want 0", bus.A_mul_valid); end
    n_checks++; if (bus.A_mul_result !== exp_result) begin n_fail++; $display("FAIL low_result_hold got %h want %h", bus.A_mul_result, exp_result); end
  endtask

  task automatic test_low_corner();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.A_mul_result !== 32'h0000_0001) begin n_fail++; $display("FAIL corner_low got %h want %h", bus.A_mul_result, 32'h1); end
    exp_result = 32'h0000_0001;
    @(posedge clk); #1;
  endtask

  task automatic test_gating();
    drive($urandom, $urandom, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.A_mul_valid !== 1'b0) begin n_fail++; $display("FAIL gated_valid cycle %0d got %b want 0", k, bus.A_mul_valid); end
      n_checks++; if (bus.A_mul_result !== exp_result) begin n_fail++; $display("FAIL gated_result got %h want %h", bus.A_mul_result, exp_result); end
    end
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [63:0] prod;
    for (int i = 0; i < 3; i++) begin a[i] = $urandom; b[i] = $urandom; end
    drive(a[0], b[0], 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) drive(a[i+1], b[i+1], 1'b0, 1'b1, 1'b1);
      else       drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      prod = ref_product(a[i], b[i]);
      exp_result = prod[31:0];
      n_checks++; if (bus.A_mul_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid op %0d got %b want 1", i, bus.A_mul_valid); end
      n_checks++; if (bus.A_mul_result !== exp_result) begin n_fail++; $display("FAIL b2b_result op %0d got %h want %h", i, bus.A_mul_result, exp_result); end
    end
    @(posedge clk); #1;
    n_checks++; if (bus.A_mul_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_valid got %b want 0", bus.A_mul_valid); end
  endtask

`ifdef MUL_HI_EN
  // Accept at T, stall through T+16 while the inputs are scrambled, result at T+17.
  task automatic test_high(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = ref_product(a, b);
    drive(a, b, 1'b1, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.A_mul_stall !== 1'b1) begin n_fail++; $display("FAIL high_stall_accept got %b want 1", bus.A_mul_stall); end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      n_checks++; if (bus.A_mul_stall !== 1'b1) begin n_fail++; $display("FAIL high_stall T+%0d got %b want 1", k, bus.A_mul_stall); end
      n_checks++; if (bus.A_mul_valid !== 1'b0) begin n_fail++; $display("FAIL high_early_valid T+%0d got %b want 0", k, bus.A_mul_valid); end
    end
    @(posedge clk); #1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    exp_result = prod[63:32];
    n_checks++; if (bus.A_mul_stall !== 1'b0) begin n_fail++; $display("FAIL high_stall_release got %b want 0", bus.A_mul_stall); end
    n_checks++; if (bus.A_mul_valid !== 1'b1) begin n_fail++; $display("FAIL high_valid got %b want 1", bus.A_mul_valid); end
    n_checks++; if (bus.A_mul_result !== exp_result) begin n_fail++; $display("FAIL high_result a=%h b=%h got %h want %h", a, b, bus.A_mul_result, exp_result); end
    @(posedge clk); #1;
    n_checks++; if (bus.A_mul_valid !== 1'b0) begin n_fail++; $display("FAIL high_valid_pulse got %b want 0", bus.A_mul_valid); end
  endtask

  task automatic test_abort();
    drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    exp_result = 32'h0;
    n_checks++; if (bus.A_mul_stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall got %b want 0", bus.A_mul_stall); end
    n_checks++; if (bus.A_mul_result !== exp_result) begin n_fail++; $display("FAIL abort_result got %h want %h", bus.A_mul_result, exp_result); end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.A_mul_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid cycle %0d got %b want 0", k, bus.A_mul_valid); end
    end
    test_low($urandom, $urandom, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_low(32'h0001_0003, 32'h0002_0005, 1'b0);
    n_checks++; if (exp_result !== 32'h000B_000F || bus.A_mul_result !== 32'h000B_000F) begin n_fail++; $display("FAIL low_example got %h want %h", bus.A_mul_result, 32'h000B_000F); end
    test_low_corner();
    for (int i = 0; i < 16; i++) test_low($urandom, $urandom, 1'b0);
    test_gating();
    test_back_to_back();
`ifdef MUL_HI_EN
    test_high(32'h0001_0003, 32'h0002_0005);
    n_checks++; if (bus.A_mul_result !== 32'h0000_0002) begin n_fail++; $display("FAIL high_example got %h want %h", bus.A_mul_result, 32'h2); end
    test_high(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++; if (bus.A_mul_result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL high_corner got %h want %h", bus.A_mul_result, 32'hFFFF_FFFE); end
    for (int i = 0; i < 6; i++) test_high($urandom, $urandom);
    test_abort();
    test_low($urandom, $urandom, 1'b0);
`else
    for (int i = 0; i < 4; i++) test_low($urandom, $urandom, 1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
